timer_array: RTL and testbench

Parametrised multi-channel timer that replaces the pair of fixed single-channel timers in the MIPS microsystem with one register-mapped block behind the Bridge. It provides NUM_CH independent down/up counters, each with a prescaler, three counting modes, a sticky pending flag and a maskable interrupt line. Per-channel IRQs feed the CPU's HWINT vector, and the OR of all IRQs is also provided.

---
 rtl/timer_array_if.sv | 23 ++
 rtl/timer_array.sv | 210 +++++++++++++++++++++
 tb/tb_timer_array.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_array_if.sv
// Register bus between the Bridge and the timer array: word address,
// write strobe and data in, combinational read data and interrupts out.
interface timer_array_if #(
    parameter int NUM_CH  = 2,
    parameter int CH_BITS = 1
);
    logic [CH_BITS+1:0] Addr;
    logic               WE;
    logic [31:0]        Din;
    logic [31:0]        Dout;
    logic [NUM_CH-1:0]  IRQ;
    logic               IRQ_ANY;

    modport master (
        output Addr, WE, Din,
        input  Dout, IRQ, IRQ_ANY
    );

    modport slave (
        input  Addr, WE, Din,
        output Dout, IRQ, IRQ_ANY
    );
endinterface

// File: rtl/timer_array.sv
// Multi-channel register-mapped timer. Each channel has CTRL / PRESET /
// COUNT / STATUS, a prescaler, one-shot / auto-reload / free-run modes and
// a sticky pending flag gated by an interrupt mask.

// One timer channel: register file, prescaler and counting FSM.
module timer_ch #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] din_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_EXPIRE} state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PSC_W-1:0]   pcnt_q, pcnt_d;
    logic               pend_q, pend_d;

    logic wr_ctrl, wr_pre, wr_stat;
    logic tick, free_run, reload, set_pend;

    // Only the low field bits of a write are meaningful.
    logic unused_din;
    assign unused_din = ^din_i;

    assign wr_ctrl  = we_i && (reg_i == 2'd0);
    assign wr_pre   = we_i && (reg_i == 2'd1);
    assign wr_stat  = we_i && (reg_i == 2'd3);
    assign tick     = (pcnt_q == psc_q);
    assign free_run = (mode_q == 2'd2);
    assign reload   = (mode_q == 2'd1);

    // Next-state: register writes, FSM transitions, count and pending update.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        psc_d    = psc_q;
        preset_d = preset_q;
        count_d  = count_q;
        pcnt_d   = pcnt_q;
        pend_d   = pend_q;
        set_pend = 1'b0;

        if (wr_ctrl) begin
            en_d   = din_i[0];
            mode_d = din_i[2:1];
            im_d   = din_i[3];
            psc_d  = din_i[8 +: PSC_W];
        end
        if (wr_pre) begin
            preset_d = din_i[CNT_W-1:0];
        end

        // An expiry or wrap on this edge raises pending even if EN is
        // being cleared at the same time.
        if (state_q == S_CNT && tick) begin
            if (free_run) set_pend = (count_q == {CNT_W{1'b1}});
            else          set_pend = (count_q <= CNT_W'(1));
        end

        // EN low stops the channel at once; COUNT keeps its value.
        if (!en_d) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_LOAD;
                S_LOAD: begin
                    pcnt_d  = '0;
                    count_d = free_run ? '0 : preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (tick) begin
                        pcnt_d = '0;
                        if (free_run) begin
                            count_d = count_q + CNT_W'(1);
                        end else if (count_q <= CNT_W'(1)) begin
                            count_d = '0;
                            state_d = S_EXPIRE;
                        end else begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end else begin
                        pcnt_d = pcnt_q + PSC_W'(1);
                    end
                end
                S_EXPIRE: begin
                    if (reload || free_run) begin
                        state_d = S_LOAD;
                    end else begin
                        // One-shot ends by dropping EN, unless software
                        // rewrites EN=1 on this very edge.
                        state_d = S_IDLE;
                        if (!wr_ctrl) en_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Set beats a simultaneous clear.
        if (wr_stat && din_i[0]) pend_d = 1'b0;
        if (set_pend)            pend_d = 1'b1;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'd0;
            im_q     <= 1'b0;
            psc_q    <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pcnt_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            psc_q    <= psc_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pcnt_q   <= pcnt_d;
            pend_q   <= pend_d;
        end
    end

    // Read mux for this channel; unused bits read zero.
    always_comb begin
        rdata_o = '0;
        case (reg_i)
            2'd0: begin
                rdata_o[0]          = en_q;
                rdata_o[2:1]        = mode_q;
                rdata_o[3]          = im_q;
                rdata_o[8 +: PSC_W] = psc_q;
            end
            2'd1:    rdata_o[CNT_W-1:0] = preset_q;
            2'd2:    rdata_o[CNT_W-1:0] = count_q;
            default: rdata_o[0]         = pend_q;
        endcase
    end

    assign irq_o = pend_q & im_q;
endmodule

// Channel array with address decode and read-back selection.
module timer_array #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int PSC_W   = 8,
    parameter int CH_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    timer_array_if.slave bus
);
    logic [CH_BITS-1:0]            chan;
    logic [1:0]                    rsel;
    logic [NUM_CH-1:0][31:0]       rdata;
    logic [NUM_CH-1:0]             irq;
    logic [31:0]                   dout;

    assign chan = bus.Addr[CH_BITS+1:2];
    assign rsel = bus.Addr[1:0];

    // Channel indices past NUM_CH never match, so writes there are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_ch #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .we_i    (bus.WE && (chan == CH_BITS'(i))),
            .reg_i   (rsel),
            .din_i   (bus.Din),
            .rdata_o (rdata[i]),
            .irq_o   (irq[i])
        );
    end

    // Select the addressed channel's read data; unmapped channels read 0.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan == CH_BITS'(i)) dout = rdata[i];
        end
    end

    assign bus.Dout    = dout;
    assign bus.IRQ     = irq;
    assign bus.IRQ_ANY = |irq;
endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: directed scenarios with literal expectations plus
// randomized register traffic, all compared every cycle against a
// behavioural model of the channels.
module tb_timer_array;
    localparam int NCH = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    timer_array_if #(.NUM_CH(NCH), .CH_BITS(2)) bus ();

    timer_array #(
        .NUM_CH  (NCH),
        .CNT_W   (8),
        .PSC_W   (8),
        .CH_BITS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;
    int m_en[NCH]     = '{default: 0};
    int m_mode[NCH]   = '{default: 0};
    int m_im[NCH]     = '{default: 0};
    int m_psc[NCH]    = '{default: 0};
    int m_preset[NCH] = '{default: 0};
    int m_count[NCH]  = '{default: 0};
    int m_pend[NCH]   = '{default: 0};
    int m_pc[NCH]     = '{default: 0};
    int m_ph[NCH]     = '{default: 0};

    task automatic m_clear();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0;
            m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0;
            m_pc[c] = 0; m_ph[c] = PH_IDLE;
        end
    endtask

    task automatic m_step();
        int ch = int'(bus.Addr[3:2]);
        int rg = int'(bus.Addr[1:0]);
        for (int c = 0; c < NCH; c++) begin
            bit wr   = bus.WE && (ch == c);
            bit wctl = wr && rg == 0;
            int en_n = wctl ? int'(bus.Din[0]) : m_en[c];
            bit frr  = (m_mode[c] == 2);
            bit tick = (m_ph[c] == PH_RUN) && (m_pc[c] == m_psc[c]);
            bit fire = tick && (frr ? (m_count[c] == 255) : (m_count[c] <= 1));
            int ncnt = m_count[c];
            int npc  = m_pc[c];
            int nph  = m_ph[c];
            if (en_n == 0) nph = PH_IDLE;
            else if (m_ph[c] == PH_IDLE) nph = PH_LOAD;
            else if (m_ph[c] == PH_LOAD) begin
                npc = 0; ncnt = frr ? 0 : m_preset[c]; nph = PH_RUN;
            end else if (m_ph[c] == PH_RUN) begin
                if (!tick) npc = (m_pc[c] + 1) % 256;
                else begin
                    npc = 0;
                    if (frr) ncnt = (m_count[c] + 1) % 256;
                    else if (fire) begin ncnt = 0; nph = PH_DONE; end
                    else ncnt = m_count[c] - 1;
                end
            end else begin
                if (m_mode[c] == 1 || m_mode[c] == 2) nph = PH_LOAD;
                else begin nph = PH_IDLE; if (!wctl) en_n = 0; end
            end
            if (wr && rg == 3 && bus.Din[0]) m_pend[c] = 0;
            if (fire) m_pend[c] = 1;
            if (wctl) begin
                m_mode[c] = int'(bus.Din[2:1]);
                m_im[c]   = int'(bus.Din[3]);
                m_psc[c]  = int'(bus.Din[15:8]);
            end
            if (wr && rg == 1) m_preset[c] = int'(bus.Din[7:0]);
            m_en[c] = en_n; m_count[c] = ncnt; m_pc[c] = npc; m_ph[c] = nph;
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        int ch = int'(a[3:2]);
        if (ch >= NCH) return 32'd0;
        case (a[1:0])
            2'd0:    return 32'(m_psc[ch] * 256 + m_im[ch] * 8 + m_mode[ch] * 2 + m_en[ch]);
            2'd1:    return 32'(m_preset[ch]);
            2'd2:    return 32'(m_count[ch]);
            default: return 32'(m_pend[ch]);
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m_clear();
        else        m_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        logic [NCH-1:0] eirq = '0;
        for (int c = 0; c < NCH; c++) eirq[c] = (m_pend[c] != 0) && (m_im[c] != 0);
        check("model_dout", bus.Dout, m_rd(bus.Addr));
        check("model_irq", 32'(bus.IRQ), 32'(eirq));
        check("model_irq_any", 32'(bus.IRQ_ANY), 32'(|eirq));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.Addr = a; bus.Din = d; bus.WE = 1'b1;
        @(posedge clk);
        #1;
        bus.WE = 1'b0; bus.Din = '0;
    endtask

    task automatic chk_rd(input string nm, input logic [3:0] a, input logic [31:0] exp);
        bus.Addr = a;
        #1;
        check(nm, bus.Dout, exp);
    endtask

    task automatic chk_irq(input string nm, input logic [NCH-1:0] exp);
        check(nm, 32'(bus.IRQ), 32'(exp));
        check({nm, "_any"}, 32'(bus.IRQ_ANY), 32'(|exp));
    endtask

    initial begin
        reset = 1'b0; bus.WE = 1'b0; bus.Addr = '0; bus.Din = '0;
        #2;
        chk_irq("rst_irq", 3'b000);
        chk_rd("rst_ctrl0", 4'h0, 32'h0);
        chk_rd("rst_cnt1", 4'h6, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cyc(2);

        // One-shot, ch0: PRESET=3, EN|IM, mode 0.
        wr(4'h1, 32'd3);
        wr(4'h0, 32'h9);
        chk_rd("os_load", 4'h2, 32'd0);
        cyc(); chk_rd("os_c3", 4'h2, 32'd3);
        cyc(); chk_rd("os_c2", 4'h2, 32'd2);
        cyc(); chk_rd("os_c1", 4'h2, 32'd1); chk_irq("os_noirq", 3'b000);
        cyc(); chk_rd("os_c0", 4'h2, 32'd0); chk_irq("os_irq", 3'b001);
        chk_rd("os_ctrl_run", 4'h0, 32'h9);
        cyc(); chk_rd("os_ctrl_done", 4'h0, 32'h8);
        wr(4'h3, 32'd1); chk_irq("os_clr", 3'b000);

        // Auto-reload with PSC=1, ch1: PRESET=2, period 6 cycles.
        wr(4'h5, 32'd2);
        wr(4'h4, 32'h10B);
        cyc(); chk_rd("ar_k1", 4'h6, 32'd2);
        cyc(); chk_rd("ar_k2", 4'h6, 32'd2);
        cyc(); chk_rd("ar_k3", 4'h6, 32'd1);
        cyc(); chk_irq("ar_k4", 3'b000);
        cyc(); chk_irq("ar_k5", 3'b010); chk_rd("ar_k5c", 4'h6, 32'd0);
        wr(4'h7, 32'd1); chk_irq("ar_clr", 3'b000);
        cyc(); chk_rd("ar_k7", 4'h6, 32'd2);
        cyc(3); chk_irq("ar_k10", 3'b000); chk_rd("ar_k10c", 4'h6, 32'd1);
        cyc(); chk_irq("ar_k11", 3'b010);
        wr(4'h4, 32'h8);
        wr(4'h7, 32'd1); chk_irq("ar_off", 3'b000);
        chk_rd("ar_hold", 4'h6, 32'd0);

        // Free-run wrap on ch2 with IM=0, then unmask.
        wr(4'h8, 32'h5);
        cyc(); chk_rd("fr_start", 4'hA, 32'd0);
        cyc(255); chk_rd("fr_255", 4'hA, 32'd255); chk_rd("fr_nopend", 4'hB, 32'd0);
        cyc(); chk_rd("fr_wrap", 4'hA, 32'd0); chk_rd("fr_pend", 4'hB, 32'd1);
        chk_irq("fr_masked", 3'b000);
        wr(4'h8, 32'hD); chk_irq("fr_unmask", 3'b100); chk_rd("fr_norestart", 4'hA, 32'd1);
        wr(4'h8, 32'h8); chk_rd("fr_hold", 4'hA, 32'd1);
        wr(4'hB, 32'd1); chk_irq("fr_clr", 3'b000);

        // Clear and expiry on the same edge: set wins.
        wr(4'h1, 32'd1);
        wr(4'h0, 32'h1);
        cyc();
        wr(4'h3, 32'd1); chk_rd("col_pend", 4'h3, 32'd1);
        cyc(); chk_rd("col_ctrl", 4'h0, 32'h0);
        wr(4'h3, 32'd1); chk_rd("col_clr", 4'h3, 32'd0);

        // Unmapped channel 3 and read-only COUNT.
        wr(4'hC, 32'h9); chk_rd("ch3_ctrl", 4'hC, 32'd0); chk_irq("ch3_irq", 3'b000);
        chk_rd("ch3_ch0", 4'h0, 32'h0);
        wr(4'hD, 32'd7); chk_rd("ch3_pre", 4'hD, 32'd0); chk_rd("ch3_ch0pre", 4'h1, 32'd1);
        wr(4'h6, 32'h55); chk_rd("cnt_ro", 4'h6, 32'd0);

        // PRESET written mid-count takes effect at the next load.
        wr(4'h5, 32'd5);
        wr(4'h4, 32'h1);
        cyc(); chk_rd("pm_k1", 4'h6, 32'd5);
        wr(4'h5, 32'd9); chk_rd("pm_k2", 4'h6, 32'd4);
        cyc(); chk_rd("pm_k3", 4'h6, 32'd3); chk_rd("pm_pre", 4'h5, 32'd9);
        cyc(4); chk_rd("pm_done", 4'h4, 32'h0);
        wr(4'h4, 32'h1);
        cyc(); chk_rd("pm_reload", 4'h6, 32'd9);
        wr(4'h4, 32'h0);
        wr(4'h7, 32'd1);

        // Reset in the middle of counting.
        wr(4'h1, 32'd100);
        wr(4'h0, 32'h9);
        wr(4'h5, 32'd0);
        wr(4'h4, 32'hB);
        cyc(4);
        chk_irq("mr_pre", 3'b010);
        bus.Addr = 4'h2;
        reset = 1'b0;
        #1;
        check("mr_dout", bus.Dout, 32'd0);
        chk_irq("mr_irq", 3'b000);
        cyc(2);
        reset = 1'b1;
        cyc(5);
        chk_rd("mr_ctrl0", 4'h0, 32'h0);
        chk_rd("mr_cnt0", 4'h2, 32'h0);
        chk_rd("mr_cnt1", 4'h6, 32'h0);

        // Randomized register traffic.
        for (int n = 0; n < 5000; n++) begin
            logic [3:0]  a = 4'($urandom_range(0, 15));
            logic [31:0] d = $urandom;
            if (a[1:0] == 2'd0) begin
                d = (d & 32'hFFFF00F0)
                  | 32'($urandom_range(0, 9) < 8)
                  | 32'($urandom_range(0, 3) << 1)
                  | 32'($urandom_range(0, 1) << 3)
                  | 32'(($urandom_range(0, 7) == 0 ? $urandom_range(0, 255)
                                                   : $urandom_range(0, 3)) << 8);
            end else if (a[1:0] == 2'd1 && $urandom_range(0, 3) != 0) begin
                d = (d & 32'hFFFFFF00) | 32'($urandom_range(0, 12));
            end
            bus.Addr = a;
            bus.Din  = d;
            bus.WE   = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
            cyc();
        end
        bus.WE = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
